// File: rtl/vds_pkg.sv
// Shared types and geometry helpers for the NxN streaming video downscaler.
package vds_pkg;

   typedef enum logic {VDS_AVG = 1'b0, VDS_DEC = 1'b1} vds_mode_t;

   function automatic int vds_k(input int s);
      return 1 << s;
   endfunction

   function automatic int vds_acc_w(input int dw, input int s);
      return dw + 2 * s;
   endfunction

   function automatic int vds_groups(input int mw, input int s);
      return mw >> s;
   endfunction

   function automatic int vds_addr_w(input int mw, input int s);
      return (vds_groups(mw, s) > 1) ? $clog2(vds_groups(mw, s)) : 1;
   endfunction

endpackage

// File: rtl/vds_line_accum.sv
// Row-sum line buffer: one partial block sum per horizontal group, async read, sync write.
module vds_line_accum
   import vds_pkg::*;
#(
   parameter int GROUPS = 960,
   parameter int ACC_W  = 10,
   parameter int ADDR_W = 10
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [ACC_W-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [ACC_W-1:0]  o_rdata
);

   logic [ACC_W-1:0] r_mem [GROUPS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/video_downscaler_nxn.sv
// Streaming 2^S x 2^S -> 1 video downscaler (rounded average or top-left decimation)
// with a single output register and a sticky geometry error flag.
module video_downscaler_nxn
   import vds_pkg::*;
#(
   parameter int D_WIDTH    = 8,
   parameter int SCALE_LOG2 = 1,
   parameter int MAX_WIDTH  = 1920
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               up_valid,
   input  logic               up_tlast,
   input  logic               up_tuser,
   output logic               up_ready,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_valid,
   output logic               down_tlast,
   output logic               down_tuser,
   input  logic               down_ready,
   output logic               err_geom
);

   localparam int S      = SCALE_LOG2;
   localparam int K      = vds_k(S);
   localparam int ACC_W  = vds_acc_w(D_WIDTH, S);
   localparam int GROUPS = vds_groups(MAX_WIDTH, S);
   localparam int ADDR_W = vds_addr_w(MAX_WIDTH, S);
   localparam logic [S-1:0]      LAST     = S'(K - 1);
   localparam logic [ADDR_W-1:0] GRP_LAST = ADDR_W'(GROUPS - 1);
   localparam logic [ACC_W-1:0]  RND      = ACC_W'(1 << (2 * S - 1));

   function automatic logic [D_WIDTH-1:0] round_avg(input logic [ACC_W-1:0] total);
      logic [ACC_W-1:0] sum;
      sum = total + RND;
      return sum[ACC_W-1:2*S];
   endfunction

   logic [S-1:0]       r_col, r_row;
   logic [ADDR_W-1:0]  r_grp;
   logic [ACC_W-1:0]   r_hsum;
   logic               r_sof_pend, r_ovr, r_err;
   vds_mode_t          r_mode;
   logic               r_valid, r_tlast, r_tuser;
   logic [D_WIDTH-1:0] r_data;

   logic               w_acc, w_ovr, w_dec, w_gdone, w_last_row, w_out, w_we;
   logic [S-1:0]       w_col, w_row;
   logic [ADDR_W-1:0]  w_grp;
   vds_mode_t          w_mode;
   logic [ACC_W-1:0]   w_pix, w_hsum_next, w_lb_rd, w_wdata, w_total;

   assign up_ready = !r_valid || down_ready;
   assign w_acc    = up_valid && up_ready;

   // A SOF beat is treated as pixel (0,0) of a fresh frame regardless of prior state.
   assign w_col  = up_tuser ? '0 : r_col;
   assign w_row  = up_tuser ? '0 : r_row;
   assign w_grp  = up_tuser ? '0 : r_grp;
   assign w_ovr  = r_ovr && !up_tuser;
   assign w_mode = up_tuser ? vds_mode_t'(mode) : r_mode;
   assign w_dec  = (w_mode == VDS_DEC);

   assign w_pix       = ACC_W'(up_data);
   assign w_hsum_next = (w_col == '0) ? w_pix : (w_dec ? r_hsum : r_hsum + w_pix);
   assign w_gdone     = (w_col == LAST) && !w_ovr;
   assign w_last_row  = (w_row == LAST);
   assign w_out       = w_acc && w_gdone && w_last_row;
   assign w_we        = w_acc && w_gdone && !w_last_row && ((w_row == '0) || !w_dec);
   assign w_wdata     = (w_row == '0) ? w_hsum_next : w_lb_rd + w_hsum_next;
   assign w_total     = w_lb_rd + w_hsum_next;

   vds_line_accum #(
      .GROUPS (GROUPS),
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_lb (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_grp),
      .i_wdata (w_wdata),
      .i_raddr (w_grp),
      .o_rdata (w_lb_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_grp      <= '0;
         r_hsum     <= '0;
         r_sof_pend <= 1'b0;
         r_ovr      <= 1'b0;
         r_err      <= 1'b0;
         r_mode     <= VDS_AVG;
      end else if (w_acc) begin
         r_hsum <= w_hsum_next;
         if (up_tuser) begin
            r_mode     <= vds_mode_t'(mode);
            r_sof_pend <= 1'b1;
            r_ovr      <= 1'b0;
            if ((r_col != '0) || (r_row != '0) || (r_grp != '0) || r_ovr) r_err <= 1'b1;
         end
         if (w_out) r_sof_pend <= 1'b0;
         // End of line: incomplete groups are dropped and flagged.
         if (up_tlast) begin
            r_col <= '0;
            r_grp <= '0;
            r_ovr <= 1'b0;
            r_row <= w_last_row ? '0 : w_row + 1'b1;
            if (w_col != LAST) r_err <= 1'b1;
         end else if (w_ovr) begin
            r_err <= 1'b1;
         end else if (w_col == LAST) begin
            r_col <= '0;
            r_row <= w_row;
            if (w_grp == GRP_LAST) begin
               r_grp <= w_grp;
               r_ovr <= 1'b1;
            end else begin
               r_grp <= w_grp + 1'b1;
            end
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
            r_grp <= w_grp;
         end
      end
   end

   // Output register: loaded by a completing beat, drained by down_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tlast <= 1'b0;
         r_tuser <= 1'b0;
      end else if (w_out) begin
         r_valid <= 1'b1;
         r_data  <= w_dec ? w_lb_rd[D_WIDTH-1:0] : round_avg(w_total);
         r_tlast <= up_tlast;
         r_tuser <= r_sof_pend;
      end else if (down_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign down_valid = r_valid;
   assign down_data  = r_data;
   assign down_tlast = r_tlast;
   assign down_tuser = r_tuser;
   assign err_geom   = r_err;

endmodule

// File: tb/tb_video_downscaler_nxn.sv
// Self-checking bench: table-driven 4x2 frames through a 2x2 instance with a scoreboard,
// plus hand-written sequences for rounding (4x4 instance), geometry errors and async reset.
module tb_video_downscaler_nxn;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] up_data = '0;
   logic       up_valid = 1'b0, up_tlast = 1'b0, up_tuser = 1'b0;
   logic       up_ready;
   logic [7:0] down_data;
   logic       down_valid, down_tlast, down_tuser;
   logic       down_ready = 1'b1;
   logic       err_geom;

   logic       m2 = 1'b0;
   logic [7:0] u2_data = '0;
   logic       u2_valid = 1'b0, u2_tlast = 1'b0, u2_tuser = 1'b0;
   logic       u2_ready;
   logic [7:0] d2_data;
   logic       d2_valid, d2_tlast, d2_tuser;
   logic       d2_ready = 1'b1;
   logic       err2;

   always #5 clk = ~clk;

   video_downscaler_nxn #(.D_WIDTH(8), .SCALE_LOG2(1), .MAX_WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .mode(mode),
      .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
      .up_ready(up_ready),
      .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
      .down_tuser(down_tuser), .down_ready(down_ready), .err_geom(err_geom)
   );

   video_downscaler_nxn #(.D_WIDTH(8), .SCALE_LOG2(2), .MAX_WIDTH(8)) u_dut4 (
      .clk(clk), .rst(rst), .mode(m2),
      .up_data(u2_data), .up_valid(u2_valid), .up_tlast(u2_tlast), .up_tuser(u2_tuser),
      .up_ready(u2_ready),
      .down_data(d2_data), .down_valid(d2_valid), .down_tlast(d2_tlast),
      .down_tuser(d2_tuser), .down_ready(d2_ready), .err_geom(err2)
   );

   typedef struct {
      int mode;
      int pix [8];
      int e0;
      int e1;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } exp_t;

   vec_t vecs [6];
   exp_t q [$];
   int   checks = 0;
   int   failures = 0;
   int   bp_mode = 0;
   int   bp_cnt = 0;
   logic mon_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [7:0] d, input logic l, input logic u);
      int n;
      up_data  = d;
      up_tlast = l;
      up_tuser = u;
      up_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (up_ready) break;
         n++;
         if (n > 200) begin
            chk("up_ready_timeout", 32'(up_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      up_valid = 1'b0;
      up_tlast = 1'b0;
      up_tuser = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic l, input logic u);
      exp_t e;
      e.d = d;
      e.l = l;
      e.u = u;
      q.push_back(e);
   endtask

   task automatic send_vec(input int idx);
      mode = vecs[idx].mode[0];
      push_exp(8'(vecs[idx].e0), 1'b0, 1'b1);
      push_exp(8'(vecs[idx].e1), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_beat(8'(vecs[idx].pix[i]), (i == 3) || (i == 7), i == 0);
         if (bp_mode == 0 && (i == 4 || i == 5))
            chk($sformatf("latency_v%0d_b%0d", idx, i), 32'(down_valid), (i == 5) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
   endtask

   // Sink readiness patterns, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bp_cnt++;
         case (bp_mode)
            1:       down_ready = bp_cnt[0];
            2:       down_ready = (bp_cnt % 8) >= 5;
            3:       down_ready = 1'b0;
            default: down_ready = 1'b1;
         endcase
      end
   end

   // Output monitor and scoreboard.
   initial begin
      exp_t       e;
      logic       hold;
      logic [9:0] held;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst && mon_en) begin
            chk("up_ready_rule", 32'(up_ready), 32'(!down_valid || down_ready));
            if (hold) chk("hold_stable", 32'({down_valid, down_data, down_tlast, down_tuser}),
                          32'({1'b1, held}));
            hold = down_valid && !down_ready;
            held = {down_data, down_tlast, down_tuser};
            if (down_valid && down_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 32'(down_data), 32'hFFFF_FFFF);
               end else begin
                  e = q.pop_front();
                  chk("out_data",  32'(down_data),  32'(e.d));
                  chk("out_tlast", 32'(down_tlast), 32'(e.l));
                  chk("out_tuser", 32'(down_tuser), 32'(e.u));
               end
            end
         end else begin
            hold = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{0, '{10, 20, 30, 40, 30, 40, 50, 60}, 25, 45};
      vecs[1] = '{1, '{10, 20, 30, 40, 30, 40, 50, 60}, 10, 30};
      vecs[2] = '{0, '{255, 255, 255, 255, 255, 255, 255, 255}, 255, 255};
      vecs[3] = '{0, '{0, 0, 1, 1, 0, 1, 1, 0}, 0, 1};
      vecs[4] = '{0, '{2, 2, 200, 100, 1, 1, 50, 51}, 2, 100};
      vecs[5] = '{1, '{7, 99, 5, 99, 0, 0, 0, 0}, 7, 5};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_down_valid", 32'(down_valid), 32'd0);
      chk("rst_down_data",  32'(down_data),  32'd0);
      chk("rst_down_tlast", 32'(down_tlast), 32'd0);
      chk("rst_down_tuser", 32'(down_tuser), 32'd0);
      chk("rst_err_geom",   32'(err_geom),   32'd0);
      rst = 1'b1;
      tick(1);
      chk("up_ready_after_rst", 32'(up_ready), 32'd1);

      // Table-driven frames, no backpressure then two backpressure patterns
      for (int b = 0; b < 3; b++) begin
         bp_mode = b;
         for (int v = 0; v < 6; v++) send_vec(v);
         drain();
      end
      bp_mode = 0;
      tick(2);
      chk("err_clean_frames", 32'(err_geom), 32'd0);

      // 4x4 rounding: fifteen 255s and one 0
      for (int i = 0; i < 16; i++) begin
         u2_data  = (i == 6) ? 8'd0 : 8'd255;
         u2_tuser = (i == 0);
         u2_tlast = (i % 4) == 3;
         u2_valid = 1'b1;
         tick(1);
         if (i == 14) chk("s2_no_early_out", 32'(d2_valid), 32'd0);
      end
      u2_valid = 1'b0;
      chk("s2_valid", 32'(d2_valid), 32'd1);
      chk("s2_data",  32'(d2_data),  32'd239);
      chk("s2_tlast", 32'(d2_tlast), 32'd1);
      chk("s2_tuser", 32'(d2_tuser), 32'd1);
      chk("s2_err",   32'(err2),     32'd0);

      // Width 5 with K=2: two outputs on the output line, no tlast, error flagged
      mode = 1'b0;
      push_exp(8'd100, 1'b0, 1'b1);
      push_exp(8'd100, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 5; c++)
            drive_beat(8'd100, c == 4, (r == 0) && (c == 0));
      drain();
      chk("err_width5", 32'(err_geom), 32'd1);

      // Asynchronous reset while an output is held
      bp_mode = 3;
      tick(2);
      for (int i = 0; i < 4; i++) drive_beat(8'd40, i == 3, i == 0);
      drive_beat(8'd40, 1'b0, 1'b0);
      drive_beat(8'd40, 1'b1, 1'b0);
      chk("pre_rst_valid", 32'({down_valid, down_tlast, down_tuser}), 32'b111);
      mon_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", 32'(down_valid), 32'd0);
      chk("async_rst_tlast", 32'(down_tlast), 32'd0);
      chk("async_rst_tuser", 32'(down_tuser), 32'd0);
      chk("async_rst_err",   32'(err_geom),   32'd0);
      q.delete();
      bp_mode = 0;
      tick(2);
      rst = 1'b1;
      mon_en = 1'b1;
      tick(1);

      // SOF arriving at row 1: partial frame discarded, next frame decodes
      for (int i = 0; i < 4; i++) drive_beat(8'd77, i == 3, i == 0);
      chk("err_before_midsof", 32'(err_geom), 32'd0);
      send_vec(0);
      drain();
      chk("err_midsof", 32'(err_geom), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
